// File: rtl/pwm_gen.sv
// rtl/pwm_gen.sv - single-channel PWM timing core with period-boundary shadow loading
module pwm_gen #(
  parameter int WIDTH   = 16,
  parameter int PRESC_W = 8
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               enable,
  input  logic               polarity,
  input  logic [PRESC_W-1:0] prescale,
  input  logic [WIDTH-1:0]   period,
  input  logic [WIDTH-1:0]   duty,
  input  logic               load,
  output logic               pwm_o,
  output logic               cycle_done,
  output logic               load_ack,
  output logic [WIDTH-1:0]   count_o
);

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic [PRESC_W-1:0] presc_cnt;
  logic [WIDTH-1:0]   cnt;
  logic [PRESC_W-1:0] act_presc;
  logic [WIDTH-1:0]   act_period;
  logic [WIDTH-1:0]   act_duty;
  logic               pending;

  logic run_now;
  logic tick;
  logic boundary;
  logic adopt;
  logic ack_next;
  logic raw_next;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= ST_STOP;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = ST_STOP;
    if (enable) begin
      state_next = ST_RUN;
    end
  end

  // run_now is low on the enable-drop edge so that edge behaves like STOP
  always_comb begin
    run_now  = 1'b0;
    tick     = 1'b0;
    boundary = 1'b0;
    adopt    = 1'b0;
    ack_next = 1'b0;
    raw_next = 1'b0;
    if (state == ST_RUN) begin
      run_now  = enable;
      tick     = enable && (presc_cnt == act_presc);
      boundary = tick && (cnt == act_period);
      adopt    = boundary && (pending || load);
      ack_next = adopt;
      raw_next = enable && (cnt < act_duty);
    end else begin
      adopt    = enable || load;
      ack_next = load;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      presc_cnt  <= '0;
      cnt        <= '0;
      act_presc  <= '0;
      act_period <= '0;
      act_duty   <= '0;
      pending    <= 1'b0;
      pwm_o      <= 1'b0;
      cycle_done <= 1'b0;
      load_ack   <= 1'b0;
    end else begin
      pwm_o      <= raw_next ^ polarity;
      cycle_done <= boundary;
      load_ack   <= ack_next;

      if (adopt) begin
        act_presc  <= prescale;
        act_period <= period;
        act_duty   <= duty;
      end

      if (!run_now) begin
        presc_cnt <= '0;
        cnt       <= '0;
        pending   <= 1'b0;
      end else begin
        if (tick) begin
          presc_cnt <= '0;
        end else begin
          presc_cnt <= presc_cnt + 1'b1;
        end
        if (boundary) begin
          cnt     <= '0;
          pending <= 1'b0;
        end else begin
          if (tick) begin
            cnt <= cnt + 1'b1;
          end
          if (load) begin
            pending <= 1'b1;
          end
        end
      end
    end
  end

  assign count_o = cnt;

endmodule

// File: tb/tb_pwm_gen.sv
// tb/tb_pwm_gen.sv - self-checking bench for pwm_gen against a phase-based reference model
module tb_pwm_gen;

  localparam int WIDTH   = 16;
  localparam int PRESC_W = 8;
  localparam int BUDGET  = 2000;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               enable = 1'b0;
  logic               polarity = 1'b0;
  logic               load = 1'b0;
  logic [PRESC_W-1:0] prescale = '0;
  logic [WIDTH-1:0]   period = '0;
  logic [WIDTH-1:0]   duty = '0;
  logic               pwm_o;
  logic               cycle_done;
  logic               load_ack;
  logic [WIDTH-1:0]   count_o;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  pwm_gen #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .enable    (enable),
    .polarity  (polarity),
    .prescale  (prescale),
    .period    (period),
    .duty      (duty),
    .load      (load),
    .pwm_o     (pwm_o),
    .cycle_done(cycle_done),
    .load_ack  (load_ack),
    .count_o   (count_o)
  );

  always #5 clk = ~clk;

  // Reference model: position within the PWM period measured in clocks
  bit m_run;
  int m_phase;
  int m_ap;
  int m_aper;
  int m_ad;
  bit m_pend;
  bit exp_pwm;
  bit exp_cd;
  bit exp_la;
  int exp_cnt;
  int m_len;
  int m_c;

  task automatic adopt();
    m_ap   = int'(prescale);
    m_aper = int'(period);
    m_ad   = int'(duty);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run = 0; m_phase = 0; m_ap = 0; m_aper = 0; m_ad = 0; m_pend = 0;
      exp_pwm = 0; exp_cd = 0; exp_la = 0; exp_cnt = 0;
    end else begin
      if (!m_run) begin
        exp_pwm = polarity;
        exp_cd  = 0;
        exp_la  = load;
        if (enable) begin
          adopt();
          m_phase = 0;
          m_pend  = 0;
          m_run   = 1;
        end else if (load) begin
          adopt();
        end
      end else if (!enable) begin
        exp_pwm = polarity;
        exp_cd  = 0;
        exp_la  = 0;
        m_run   = 0;
        m_phase = 0;
        m_pend  = 0;
      end else begin
        m_len   = (m_ap + 1) * (m_aper + 1);
        m_c     = m_phase / (m_ap + 1);
        exp_pwm = (m_c < m_ad) ^ polarity;
        if (m_phase == m_len - 1) begin
          exp_cd = 1;
          exp_la = m_pend || load;
          if (exp_la) adopt();
          m_pend  = 0;
          m_phase = 0;
        end else begin
          exp_cd  = 0;
          exp_la  = 0;
          m_pend  = m_pend | load;
          m_phase = m_phase + 1;
        end
      end
      exp_cnt = m_run ? m_phase / (m_ap + 1) : 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("model_pwm_o", 32'(pwm_o), 32'(exp_pwm));
      chk("model_cycle_done", 32'(cycle_done), 32'(exp_cd));
      chk("model_load_ack", 32'(load_ack), 32'(exp_la));
      chk("model_count_o", 32'(count_o), 32'(exp_cnt));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_count(input int v);
    int n = 0;
    while (count_o !== WIDTH'(v) && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    chk("wait_count_timeout", 32'(n < BUDGET), 32'd1);
  endtask

  task automatic wait_ack();
    int n = 0;
    while (load_ack !== 1'b1 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    chk("wait_ack_timeout", 32'(n < BUDGET), 32'd1);
  endtask

  task automatic load_pulse();
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic measure(input int n, output int highs, output int cds, output int ones);
    highs = 0; cds = 0; ones = 0;
    repeat (n) begin
      @(negedge clk);
      highs += int'(pwm_o);
      cds   += int'(cycle_done);
      if (count_o == 1) ones++;
    end
  endtask

  int hi, cd, on;

  initial begin
    step(3);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset_pwm_o", 32'(pwm_o), 32'd0);
    chk("reset_cycle_done", 32'(cycle_done), 32'd0);
    chk("reset_load_ack", 32'(load_ack), 32'd0);
    chk("reset_count_o", 32'(count_o), 32'd0);
    polarity = 1'b1;
    step(1);
    chk("stop_polarity", 32'(pwm_o), 32'd1);
    polarity = 1'b0;

    prescale = 0; period = 9; duty = 3; enable = 1'b1;
    step(1);
    chk("no_ack_on_start", 32'(load_ack), 32'd0);
    step(3);
    measure(10, hi, cd, on);
    chk("p9d3_high", 32'(hi), 32'd3);
    chk("p9d3_cd", 32'(cd), 32'd1);
    measure(30, hi, cd, on);
    chk("p9d3_cd30", 32'(cd), 32'd3);

    wait_count(4);
    duty = 8;
    load_pulse();
    chk("load_deferred", 32'(load_ack), 32'd0);
    wait_ack();
    chk("ack_with_cd", 32'(cycle_done), 32'd1);
    measure(10, hi, cd, on);
    chk("d8_high", 32'(hi), 32'd8);

    wait_count(5);
    enable = 1'b0;
    step(1);
    chk("drop_count", 32'(count_o), 32'd0);
    chk("drop_pwm", 32'(pwm_o), 32'd0);
    chk("drop_cd", 32'(cycle_done), 32'd0);

    duty = 3; enable = 1'b1;
    step(4);
    wait_count(9);
    duty = 5;
    load_pulse();
    chk("boundary_ack", 32'(load_ack), 32'd1);
    chk("boundary_cd", 32'(cycle_done), 32'd1);
    measure(10, hi, cd, on);
    chk("d5_high", 32'(hi), 32'd5);

    duty = 0;
    load_pulse();
    wait_ack();
    measure(10, hi, cd, on);
    chk("d0_high", 32'(hi), 32'd0);

    duty = 15;
    load_pulse();
    wait_ack();
    measure(10, hi, cd, on);
    chk("d15_high", 32'(hi), 32'd10);

    period = 0; duty = 1;
    load_pulse();
    wait_ack();
    measure(5, hi, cd, on);
    chk("p0_cd", 32'(cd), 32'd5);

    prescale = 2; period = 3; duty = 2;
    load_pulse();
    wait_ack();
    measure(12, hi, cd, on);
    chk("ps2_high", 32'(hi), 32'd6);
    chk("ps2_cd", 32'(cd), 32'd1);
    chk("ps2_hold", 32'(on), 32'd3);

    polarity = 1'b1;
    wait_count(2);
    #2 rst = 1'b1;
    #1;
    chk("async_pwm_o", 32'(pwm_o), 32'd0);
    chk("async_count_o", 32'(count_o), 32'd0);
    chk("async_cd", 32'(cycle_done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    polarity = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 63) == 0) enable = ~enable;
      if ($urandom_range(0, 127) == 0) polarity = ~polarity;
      load = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) begin
        prescale = PRESC_W'($urandom_range(0, 3));
        period   = WIDTH'($urandom_range(0, 12));
        duty     = WIDTH'($urandom_range(0, 15));
      end
    end
    load = 1'b0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_gen.md
# pwm_gen

Single-channel PWM timing core sitting directly below the Wishbone register front end of the `pwm_wb` user project. It takes prescale/period/duty values held in the front end's registers and generates the PWM waveform that goes to an `io_out` pad. Programmed values go into active shadow registers only at a period boundary, so the waveform never glitches. It also reports period-end and load-acknowledge pulses, which the front end uses for `irq` and status.

## Interface
- `WIDTH`, 16, width of period/duty counter
- `PRESC_W`, 8, width of prescaler
- `wb_clk_i`  in  1  single clock for the block
- `wb_rst_i`  in  1  reset, asynchronous, active-high
- `enable`  in  1  level; 1 = run, 0 = stopped
- `polarity`  in  1  0 = active-high output, 1 = inverted
- `prescale`  in  PRESC_W  counter advances once every prescale+1 clocks
- `period`  in  WIDTH  counter runs 0..period (period+1 counts per PWM cycle)
- `duty`  in  WIDTH  active while count < duty
- `load`  in  1  one-cycle request to adopt current prescale/period/duty
- `pwm_o`  out  1  registered PWM output
- `cycle_done`  out  1  one-cycle pulse per completed PWM period
- `load_ack`  out  1  one-cycle pulse when shadow registers are updated
- `count_o`  out  WIDTH  current counter value, for readback

## Operation
- Registers: `presc_cnt`, `cnt`, `act_presc`, `act_period`, `act_duty`, `pending`.
- The block has two states, STOP and RUN. RUN is entered when `enable` = 1.
- STOP:
  - `presc_cnt` = `cnt` = 0.
  - `pwm_o` = `polarity`, which is the inactive level.
  - `load` copies the inputs to the active registers on the next edge, pulses `load_ack`, and leaves `pending` = 0.
- STOP to RUN, on the first edge with `enable` = 1:
  - The active registers are loaded from the inputs.
  - `cnt` and `presc_cnt` are set to 0.
  - `pending` is cleared.
  - No `load_ack` pulse is issued unless `load` is also high.
- RUN to STOP, on the first edge with `enable` = 0:
  - The counters clear and `pending` clears.
  - `pwm_o` goes inactive.
  - No `cycle_done` is issued for the partial period.
- Prescaler in RUN:
  - tick = (`presc_cnt` == `act_presc`).
  - On a tick, `presc_cnt` returns to 0; otherwise it increments.
  - `prescale` = 0 gives a tick every clock.
- Counter in RUN:
  - On a tick, `cnt` increments.
  - boundary = tick && (`cnt` == `act_period`). At a boundary, `cnt` returns to 0 and `cycle_done` pulses.
  - If `period` = 0, every tick is a boundary.
- Loading in RUN:
  - `load` sets `pending`.
  - At the next boundary, the active registers sample the live inputs, `pending` clears, and `load_ack` pulses.
  - If `load` arrives in the same cycle as a boundary, it is applied at that boundary.
  - Repeated `load` pulses while `pending` = 1 merge into one update.
- Output: raw = RUN && (`cnt` < `act_duty`), compared unsigned; `pwm_o` = raw XOR `polarity`.
  - `duty` = 0 gives a constant inactive output.
  - `duty` > `period` gives a constant active output.
- `count_o` = `cnt`.

## Timing
- Reset values:
  - `pwm_o` = 0.
  - `cycle_done` = `load_ack` = 0.
  - `count_o` = 0.
  - All active registers = 0, `pending` = 0, state STOP.
  - Reset takes effect immediately and asynchronously, including in the middle of a period.
- `pwm_o`, `cycle_done` and `load_ack` are registered. Each follows the `cnt`/boundary condition that causes it by exactly one clock.
- PWM period = (`act_presc`+1)·(`act_period`+1) clocks. High time = (`act_presc`+1)·min(`act_duty`, `act_period`+1) clocks.
- New values affect `pwm_o` starting with the first count-0 cycle after the boundary, so there are no partial periods.
- `polarity` is not shadowed. A change takes effect one clock later.

## Test plan
- Reset with all inputs 0, then release → all outputs 0, STOP. After `polarity`=1, `pwm_o`=1 one clock later.
- Enable with `prescale`=0, `period`=9, `duty`=3, `polarity`=0 → `pwm_o` high 3 clocks and low 7, repeating. `cycle_done` is 1 clock wide every 10 clocks.
- Enable with `prescale`=2, `period`=3, `duty`=2 → 12-clock period, 6 clocks high. `count_o` holds each value for 3 clocks.
- In RUN, change to `duty`=8, pulse `load` at `cnt`=4 → old waveform finishes its period. `load_ack` and `cycle_done` pulse together, then the next period is high 8 clocks.
- Boundary cases in RUN:
  - `duty`=0 → output constantly low.
  - `duty`=15 with `period`=9 → output constantly high.
  - `period`=0 → `cycle_done` every tick.
  - `load` in the same cycle as a boundary → applied immediately.
- Drop `enable` at `cnt`=5 → next clock `count_o`=0, `pwm_o`=`polarity`, no `cycle_done`. Assert `wb_rst_i` mid-period → outputs clear without waiting for a clock edge.
